// File: rtl/io_pkg.sv
// Shared register-offset encoding and port width for the memory-mapped IO port bank.
package io_pkg;

  localparam int IO_PORT_W = 8;

  typedef enum logic [1:0] {
    REG_DATA  = 2'd0,
    REG_DIR   = 2'd1,
    REG_IFLAG = 2'd2,
    REG_IMASK = 2'd3
  } reg_e;

endpackage

// File: rtl/io_sync.sv
// Two-flop pin synchroniser plus a history flop, so the caller can detect rising edges.
module io_sync #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] s2,
  output logic [W-1:0] s3
);

  logic [W-1:0] s1;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else begin
      s1 <= d;
      s2 <= s1;
      s3 <= s2;
    end
  end

endmodule

// File: rtl/io_port_bank.sv
// Bank of NUM_PORTS 8-bit bidirectional ports with rising-edge interrupt flags,
// decoded as four byte registers per port starting at BASE_ADDR.
module io_port_bank
  import io_pkg::*;
#(
  parameter int          NUM_PORTS = 2,
  parameter logic [15:0] BASE_ADDR = 16'h8400
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [15:0]                    bus_addr,
  input  logic [7:0]                     bus_wdata,
  input  logic                           bus_we,
  input  logic                           bus_wr_phase,
  output logic                           bus_sel,
  output logic [7:0]                     bus_rdata,
  output logic                           irq,
  input  logic [IO_PORT_W*NUM_PORTS-1:0] port_in,
  output logic [IO_PORT_W*NUM_PORTS-1:0] port_out,
  output logic [IO_PORT_W*NUM_PORTS-1:0] port_oe
);

  // One extra bit keeps the upper bound from wrapping when the window ends at 0xFFFF.
  localparam logic [16:0] WIN_LO = {1'b0, BASE_ADDR};
  localparam logic [16:0] WIN_HI = WIN_LO + 17'(4 * NUM_PORTS);

  logic [NUM_PORTS-1:0][IO_PORT_W-1:0] out_q, oe_q, iflag_q, imask_q;
  logic [NUM_PORTS-1:0][IO_PORT_W-1:0] s2, s3, oe_next, edge_ev, clr;
  logic [5:0]  offset;
  logic [3:0]  port_idx;
  reg_e        reg_sel;
  logic        wr_en;
  logic [1:0]  arm_cnt;
  logic        armed;
  logic [7:0]  rd_val;

  assign bus_sel  = ({1'b0, bus_addr} >= WIN_LO) && ({1'b0, bus_addr} < WIN_HI);
  // Window is at most 64 bytes and 4-byte aligned, so the low six bits decode it fully.
  assign offset   = bus_addr[5:0] - BASE_ADDR[5:0];
  assign port_idx = offset[5:2];
  assign reg_sel  = reg_e'(offset[1:0]);
  assign wr_en    = bus_we && bus_wr_phase && bus_sel;
  assign armed    = (arm_cnt == 2'd3);

  assign port_out = out_q;
  assign port_oe  = oe_q;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_sync
    io_sync #(.W(IO_PORT_W)) u_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .d       (port_in[IO_PORT_W*p +: IO_PORT_W]),
      .s2      (s2[p]),
      .s3      (s3[p])
    );
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    oe_next = oe_q;
    clr     = '0;
    edge_ev = '0;
    rd_val  = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (wr_en && port_idx == 4'(p)) begin
        if (reg_sel == REG_DIR)   oe_next[p] = bus_wdata;
        if (reg_sel == REG_IFLAG) clr[p]     = bus_wdata;
      end
      // Using the incoming direction masks events from the very edge a bit turns output.
      if (armed) edge_ev[p] = s2[p] & ~s3[p] & ~oe_next[p];
      if (bus_sel && port_idx == 4'(p)) begin
        case (reg_sel)
          REG_DATA:  rd_val = (oe_q[p] & out_q[p]) | (~oe_q[p] & s2[p]);
          REG_DIR:   rd_val = oe_q[p];
          REG_IFLAG: rd_val = iflag_q[p];
          REG_IMASK: rd_val = imask_q[p];
          default:   rd_val = '0;
        endcase
      end
    end
  end

  // NOTE: the per-port register arrays are a handful of flops, not a RAM, so they take the async reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_q     <= '0;
      oe_q      <= '0;
      iflag_q   <= '0;
      imask_q   <= '0;
      arm_cnt   <= '0;
      bus_rdata <= '0;
      irq       <= 1'b0;
    end else begin
      if (!armed) arm_cnt <= arm_cnt + 2'd1;
      oe_q <= oe_next;
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (wr_en && port_idx == 4'(p) && reg_sel == REG_DATA)  out_q[p]   <= bus_wdata;
        if (wr_en && port_idx == 4'(p) && reg_sel == REG_IMASK) imask_q[p] <= bus_wdata;
        // Set wins over a same-edge clear of the same bit.
        iflag_q[p] <= (iflag_q[p] & ~clr[p]) | edge_ev[p];
      end
      irq       <= |(iflag_q & imask_q);
      bus_rdata <= rd_val;
    end
  end

endmodule

// File: tb/tb_io_port_bank.sv
// Directed bench for io_port_bank: register table plus hand-timed pin/interrupt/reset sequences.
module tb_io_port_bank;

  localparam int NP = 2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] bus_addr;
  logic [7:0]  bus_wdata;
  logic        bus_we;
  logic        bus_wr_phase;
  logic        bus_sel;
  logic [7:0]  bus_rdata;
  logic        irq;
  logic [8*NP-1:0] port_in;
  logic [8*NP-1:0] port_out;
  logic [8*NP-1:0] port_oe;

  int n_checks = 0;
  int n_fail   = 0;

  io_port_bank #(.NUM_PORTS(NP), .BASE_ADDR(16'h8400)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .bus_addr     (bus_addr),
    .bus_wdata    (bus_wdata),
    .bus_we       (bus_we),
    .bus_wr_phase (bus_wr_phase),
    .bus_sel      (bus_sel),
    .bus_rdata    (bus_rdata),
    .irq          (irq),
    .port_in      (port_in),
    .port_out     (port_out),
    .port_oe      (port_oe)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic        ph;
    logic [15:0] addr;
    logic [7:0]  data;
    logic        sel;
    logic [7:0]  rd;
    logic [15:0] out;
    logic [15:0] oe;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
    bus_addr = a; bus_wdata = d; bus_we = 1'b1; bus_wr_phase = 1'b1;
    tick();
    bus_we = 1'b0; bus_wr_phase = 1'b0;
  endtask

  task automatic bus_read(input string name, input logic [15:0] a, input logic [7:0] exp);
    bus_addr = a; bus_we = 1'b0;
    tick();
    check(name, 32'(bus_rdata), 32'(exp));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b0; port_in = 16'hFFFF;
    bus_addr = 16'h0000; bus_wdata = 8'h00; bus_we = 1'b0; bus_wr_phase = 1'b0;

    //         wr    ph    addr      data   sel   rd     out        oe
    vecs[0]  = '{1'b1, 1'b1, 16'h8401, 8'hFF, 1'b1, 8'h00, 16'h0000, 16'h00FF};
    vecs[1]  = '{1'b1, 1'b1, 16'h8400, 8'hA5, 1'b1, 8'h00, 16'h00A5, 16'h00FF};
    vecs[2]  = '{1'b1, 1'b0, 16'h8400, 8'h00, 1'b1, 8'h00, 16'h00A5, 16'h00FF};
    vecs[3]  = '{1'b0, 1'b0, 16'h8400, 8'h00, 1'b1, 8'hA5, 16'h00A5, 16'h00FF};
    vecs[4]  = '{1'b0, 1'b0, 16'h8401, 8'h00, 1'b1, 8'hFF, 16'h00A5, 16'h00FF};
    vecs[5]  = '{1'b1, 1'b1, 16'h8405, 8'h0F, 1'b1, 8'h00, 16'h00A5, 16'h0FFF};
    vecs[6]  = '{1'b1, 1'b1, 16'h8404, 8'h03, 1'b1, 8'h00, 16'h03A5, 16'h0FFF};
    vecs[7]  = '{1'b0, 1'b0, 16'h8404, 8'h00, 1'b1, 8'hF3, 16'h03A5, 16'h0FFF};
    vecs[8]  = '{1'b1, 1'b1, 16'h8407, 8'hAA, 1'b1, 8'h00, 16'h03A5, 16'h0FFF};
    vecs[9]  = '{1'b0, 1'b0, 16'h8407, 8'h00, 1'b1, 8'hAA, 16'h03A5, 16'h0FFF};
    vecs[10] = '{1'b0, 1'b0, 16'h8406, 8'h00, 1'b1, 8'h00, 16'h03A5, 16'h0FFF};
    vecs[11] = '{1'b1, 1'b1, 16'h8408, 8'h55, 1'b0, 8'h00, 16'h03A5, 16'h0FFF};
    vecs[12] = '{1'b0, 1'b0, 16'h8408, 8'h00, 1'b0, 8'h00, 16'h03A5, 16'h0FFF};
    vecs[13] = '{1'b0, 1'b0, 16'h83FF, 8'h00, 1'b0, 8'h00, 16'h03A5, 16'h0FFF};
    vecs[14] = '{1'b1, 1'b1, 16'h8407, 8'h00, 1'b1, 8'h00, 16'h03A5, 16'h0FFF};
    vecs[15] = '{1'b0, 1'b0, 16'h8402, 8'h00, 1'b1, 8'h00, 16'h03A5, 16'h0FFF};

    // Reset state with all pins high; arm counter must block false edges.
    #1;
    check("rst_out",   32'(port_out),  32'h0);
    check("rst_oe",    32'(port_oe),   32'h0);
    check("rst_irq",   32'(irq),       32'h0);
    check("rst_rdata", 32'(bus_rdata), 32'h0);
    repeat (3) tick();
    reset_n = 1'b1;
    repeat (6) tick();
    check("arm_irq", 32'(irq), 32'h0);
    check("arm_oe",  32'(port_oe), 32'h0);
    bus_read("arm_iflag0", 16'h8402, 8'h00);
    bus_read("arm_iflag1", 16'h8406, 8'h00);

    for (int i = 0; i < 16; i++) begin
      bus_addr = vecs[i].addr; bus_wdata = vecs[i].data;
      bus_we = vecs[i].wr; bus_wr_phase = vecs[i].ph;
      #1;
      check($sformatf("v%0d_sel", i), 32'(bus_sel), 32'(vecs[i].sel));
      tick();
      bus_we = 1'b0; bus_wr_phase = 1'b0;
      if (vecs[i].wr) begin
        check($sformatf("v%0d_out", i), 32'(port_out), 32'(vecs[i].out));
        check($sformatf("v%0d_oe", i),  32'(port_oe),  32'(vecs[i].oe));
      end else begin
        check($sformatf("v%0d_rd", i), 32'(bus_rdata), 32'(vecs[i].rd));
      end
    end

    // Mixed direction: pin change reaches DATA readback on the 3rd edge.
    bus_addr = 16'h8404;
    port_in[15:8] = 8'hC0;
    tick(); tick();
    check("mix_e2", 32'(bus_rdata), 32'hF3);
    tick();
    check("mix_e3", 32'(bus_rdata), 32'hC3);

    // Interrupt path: flag at 3rd edge, irq at 4th, W1C drops irq one clk later.
    port_in[7:0] = 8'h00;
    repeat (4) tick();
    bus_write(16'h8401, 8'h00);
    bus_write(16'h8403, 8'h01);
    check("int_oe", 32'(port_oe), 32'h0F00);
    bus_addr = 16'h8402;
    port_in[0] = 1'b1;
    tick(); tick();
    check("int_e2_irq", 32'(irq), 32'h0);
    tick();
    check("int_e3_irq", 32'(irq), 32'h0);
    check("int_e3_rd",  32'(bus_rdata), 32'h00);
    tick();
    check("int_e4_irq", 32'(irq), 32'h1);
    check("int_e4_rd",  32'(bus_rdata), 32'h01);
    bus_write(16'h8402, 8'h01);
    check("w1c_e0_irq", 32'(irq), 32'h1);
    tick();
    check("w1c_e1_irq", 32'(irq), 32'h0);
    bus_read("w1c_flag", 16'h8402, 8'h00);

    // Set/clear collision: W1C on the same edge as the edge event.
    port_in[0] = 1'b0;
    repeat (4) tick();
    port_in[0] = 1'b1;
    tick(); tick();
    bus_write(16'h8402, 8'h01);
    tick();
    check("col_irq", 32'(irq), 32'h1);
    check("col_rd",  32'(bus_rdata), 32'h01);

    // Reset mid-write: outputs clear without a clock edge, arm counter restarts.
    bus_addr = 16'h8400; bus_wdata = 8'h5A; bus_we = 1'b1; bus_wr_phase = 1'b1;
    #3;
    reset_n = 1'b0;
    port_in = 16'hFFFF;
    #1;
    check("mrst_out",   32'(port_out),  32'h0);
    check("mrst_oe",    32'(port_oe),   32'h0);
    check("mrst_irq",   32'(irq),       32'h0);
    check("mrst_rdata", 32'(bus_rdata), 32'h0);
    bus_we = 1'b0; bus_wr_phase = 1'b0;
    tick(); tick();
    reset_n = 1'b1;
    bus_write(16'h8403, 8'hFF);
    bus_write(16'h8407, 8'hFF);
    repeat (6) tick();
    check("rearm_irq", 32'(irq), 32'h0);
    bus_read("rearm_iflag0", 16'h8402, 8'h00);
    bus_read("rearm_iflag1", 16'h8406, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
